csr_fifo_port_bridge: RTL and testbench
=======================================

CSR_FIFO_PORT_BRIDGE -- requirements
Module: csr_fifo_port_bridge

Interface
REQ-001 SHALL have parameter Width, default 32: FIFO and CSR data width in bits.
REQ-002 SHALL have parameter Depth, default 64: FIFO entries, power of two, at least 4.
REQ-003 SHALL have parameter TimeoutCycles, default 16: wait-cycle limit; 0 means wait indefinitely.
REQ-004 SHALL have port clk_i  in  1: the single clock.
REQ-005 SHALL have port rst_ni  in  1: reset, asynchronous and active-low.
REQ-006 SHALL have port clr_i  in  1: synchronous FIFO flush and abort of any pending request.
REQ-007 SHALL have ports req_i, req_is_wr_i  in  1 each: single-cycle CSR external-register request pulse and its direction.
REQ-008 SHALL have port wr_data_i  in  Width: CSR write data.
REQ-009 SHALL have ports wr_ack_o, rd_ack_o  out  1 each: one-cycle completion pulses.
REQ-010 SHALL have port rd_data_o  out  Width: read data, valid with rd_ack_o.
REQ-011 SHALL have port err_o  out  1: asserted with an ack that completed by timeout or flush.
REQ-012 SHALL have ports ext_rvalid_o  out  1, ext_rready_i  in  1, ext_rdata_o  out  Width: external pop port, valid/ready.
REQ-013 SHALL have ports depth_o  out  $clog2(Depth+1), full_o  out  1, empty_o  out  1.
REQ-014 SHALL have ports ovf_cnt_o, unf_cnt_o  out  16 each: timeout statistics (REQ-030).

Function
REQ-015 SHALL implement FSM states IDLE, WR_WAIT, RD_WAIT.
REQ-016 In IDLE, write req with !full: push wr_data_i in the same cycle; wr_ack_o=1 next cycle; stay IDLE.
REQ-017 In IDLE, read req with !empty and no ext pop that cycle: pop in the same cycle; rd_data_o registered; rd_ack_o=1 next cycle.
REQ-018 A write req while full SHALL latch wr_data_i and go to WR_WAIT; a read req when it cannot pop SHALL go to RD_WAIT.
REQ-019 In WAIT, each cycle: retry; on success complete as REQ-016/017 and return to IDLE.
REQ-020 In WAIT: wait counter increments per cycle; on reaching TimeoutCycles, ack with err_o=1, no push/pop, rd_data_o=0, go to IDLE.
REQ-021 Simultaneous CSR read and ext pop on a non-empty FIFO: ext pop wins; CSR read waits (REQ-018).
REQ-022 A single entry SHALL NOT be delivered to both consumers.
REQ-023 req_i outside IDLE SHALL be ignored; the CSR block never issues one.
REQ-024 clr_i SHALL empty the FIFO next cycle.
REQ-025 clr_i in WAIT, or coincident with req_i: ack next cycle with err_o=1, no push/pop, then IDLE.
REQ-026 ext_rvalid_o = !empty and !clr_i; ext_rdata_o = head entry, combinational.
REQ-027 Push and pop in the same cycle SHALL leave depth_o unchanged; depth_o SHALL be exact 0..Depth.

Reset
REQ-028 On reset: state IDLE, FIFO empty, wait counter 0.
REQ-029 On reset, all acks, err_o, rd_data_o, ovf_cnt_o and unf_cnt_o SHALL be 0; empty_o=1; full_o=0; depth_o=0.

Configuration
REQ-030 With macro I3C_FIFO_BRIDGE_STATS_EN defined: ovf_cnt_o counts write timeouts and unf_cnt_o counts read timeouts; both saturate at 16'hFFFF and clear on clr_i.
REQ-031 Without I3C_FIFO_BRIDGE_STATS_EN: ovf_cnt_o and unf_cnt_o are tied to 0, and no counter flops are present.

Structure
REQ-032 Package i3c_pkg SHALL hold the FSM state enum and the 16-bit stat counter width constant.
REQ-033 Storage SHALL be one caliptra_prim_fifo_sync instance (Pass=0, Depth=Depth, Width=Width); no other sub-modules.

Verification
REQ-034 Write 0xA5A5_0001, then CSR read -> wr_ack_o at N+1, rd_ack_o at M+1, rd_data_o=0xA5A5_0001, err_o=0.
REQ-035 Fill 64 entries, write 0xDEAD, TimeoutCycles=16 -> wr_ack_o and err_o 17 cycles after req, depth_o=64, ovf_cnt_o=1.
REQ-036 Full FIFO, write 0xBEEF, ext pop 3 cycles later -> wr_ack_o with err_o=0, the push occurs, depth_o remains 64.
REQ-037 Empty FIFO, CSR read, ext-side none, clr_i at wait cycle 5 -> rd_ack_o and err_o next cycle, rd_data_o=0.
REQ-038 One entry 0x1234, CSR read with ext_rready_i=1 in the same cycle -> ext receives 0x1234; CSR read times out with err_o=1, unf_cnt_o=1.
REQ-039 rst_ni low while in WR_WAIT -> all outputs 0, empty_o=1, no ack after release.

Source files
------------

// File: rtl/i3c_pkg.sv
// Shared types for the CSR/FIFO port bridge.
// This file holds the bridge FSM encoding and the width of the timeout statistics counters.
package i3c_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_WAIT = 2'd1,
      RD_WAIT = 2'd2
   } bridge_state_e;

   localparam int unsigned StatCntW = 16;

endpackage

// File: rtl/csr_fifo_port_bridge_if.sv
// Handshake bundle between the CSR/external consumer side and the bridge.
// The "master" modport is the requester side, and the "slave" modport is the bridge side.
interface csr_fifo_port_bridge_if #(
   parameter int unsigned Width = 32
);
   logic             req;
   logic             req_is_wr;
   logic [Width-1:0] wr_data;
   logic             clr;
   logic             wr_ack;
   logic             rd_ack;
   logic [Width-1:0] rd_data;
   logic             err;
   logic             ext_rvalid;
   logic             ext_rready;
   logic [Width-1:0] ext_rdata;

   modport master (
      output req, req_is_wr, wr_data, clr, ext_rready,
      input  wr_ack, rd_ack, rd_data, err, ext_rvalid, ext_rdata
   );

   modport slave (
      input  req, req_is_wr, wr_data, clr, ext_rready,
      output wr_ack, rd_ack, rd_data, err, ext_rvalid, ext_rdata
   );
endinterface

// File: rtl/caliptra_prim_fifo_sync.sv
// Synchronous FIFO with an exact occupancy count and an optional pass-through when empty.
// Depth must be a power of two, because the pointers carry one extra wrap bit.
module caliptra_prim_fifo_sync #(
   parameter int unsigned Width             = 16,
   parameter bit          Pass              = 1'b1,
   parameter int unsigned Depth             = 4,
   parameter bit          OutputZeroIfEmpty = 1'b1,
   localparam int unsigned DepthW           = $clog2(Depth + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_i,
   input  logic              wvalid_i,
   output logic              wready_o,
   input  logic [Width-1:0]  wdata_i,
   output logic              rvalid_o,
   input  logic              rready_i,
   output logic [Width-1:0]  rdata_o,
   output logic              full_o,
   output logic [DepthW-1:0] depth_o
);
   localparam int unsigned AW = $clog2(Depth);

   logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]      occ;
   logic [Width-1:0] mem_q [Depth];
   logic             empty, pass_thru, push, pop;

   assign occ       = wptr_q - rptr_q;
   assign empty     = (occ == '0);
   assign full_o    = (occ == (AW+1)'(Depth));
   assign depth_o   = DepthW'(occ);
   assign wready_o  = ~full_o;
   assign pass_thru = Pass && empty;
   assign rvalid_o  = ~empty | (pass_thru & wvalid_i);

   always_comb begin
      rdata_o = pass_thru ? wdata_i : mem_q[rptr_q[AW-1:0]];
      if (OutputZeroIfEmpty && !rvalid_o) rdata_o = '0;
   end

   // A pass-through word consumed in the same cycle never lands in storage.
   assign push = wvalid_i & wready_o & ~(pass_thru & rready_i) & ~clr_i;
   assign pop  = rready_i & ~empty & ~clr_i;

   always_comb begin
      wptr_d = clr_i ? '0 : wptr_q + (AW+1)'(push);
      rptr_d = clr_i ? '0 : rptr_q + (AW+1)'(pop);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/csr_fifo_port_bridge.sv
// Bridges single-cycle CSR external-register requests onto a sync FIFO that an external
// valid/ready port also drains. Timeout statistics are built only with I3C_FIFO_BRIDGE_STATS_EN.
module csr_fifo_port_bridge
   import i3c_pkg::*;
#(
   parameter int unsigned  Width         = 32,
   parameter int unsigned  Depth         = 64,
   parameter int unsigned  TimeoutCycles = 16,
   localparam int unsigned DepthW        = $clog2(Depth + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clr_i,
   input  logic                req_i,
   input  logic                req_is_wr_i,
   input  logic [Width-1:0]    wr_data_i,
   output logic                wr_ack_o,
   output logic                rd_ack_o,
   output logic [Width-1:0]    rd_data_o,
   output logic                err_o,
   output logic                ext_rvalid_o,
   input  logic                ext_rready_i,
   output logic [Width-1:0]    ext_rdata_o,
   output logic [DepthW-1:0]   depth_o,
   output logic                full_o,
   output logic                empty_o,
   output logic [StatCntW-1:0] ovf_cnt_o,
   output logic [StatCntW-1:0] unf_cnt_o
);
   localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;

   bridge_state_e    state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [Width-1:0] wdata_q, wdata_d, rd_data_q, rd_data_d;
   logic             wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d, err_q, err_d;
   logic [Width-1:0] fifo_wdata, fifo_rdata;
   logic             fifo_wready, fifo_rvalid, fifo_full;
   logic             push, csr_pop, ext_pop, csr_can_pop, tmo;

   caliptra_prim_fifo_sync #(
      .Width (Width),
      .Pass  (1'b0),
      .Depth (Depth)
   ) u_fifo (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clr_i    (clr_i),
      .wvalid_i (push),
      .wready_o (fifo_wready),
      .wdata_i  (fifo_wdata),
      .rvalid_o (fifo_rvalid),
      .rready_i (ext_pop | csr_pop),
      .rdata_o  (fifo_rdata),
      .full_o   (fifo_full),
      .depth_o  (depth_o)
   );

   // The external port has priority, so the CSR side may only take a head the ext side leaves.
   assign ext_rvalid_o = fifo_rvalid & ~clr_i;
   assign ext_pop      = ext_rvalid_o & ext_rready_i;
   assign csr_can_pop  = fifo_rvalid & ~clr_i & ~ext_pop;
   assign ext_rdata_o  = fifo_rdata;
   assign full_o       = fifo_full;
   assign empty_o      = ~fifo_rvalid;
   assign tmo          = (TimeoutCycles != 0) && (cnt_q == CntW'(TimeoutCycles - 1));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wdata_d    = wdata_q;
      rd_data_d  = rd_data_q;
      wr_ack_d   = 1'b0;
      rd_ack_d   = 1'b0;
      err_d      = 1'b0;
      push       = 1'b0;
      csr_pop    = 1'b0;
      fifo_wdata = wdata_q;
      unique case (state_q)
         IDLE: begin
            if (req_i && clr_i) begin
               wr_ack_d = req_is_wr_i;
               rd_ack_d = ~req_is_wr_i;
               err_d    = 1'b1;
               if (!req_is_wr_i) rd_data_d = '0;
            end else if (req_i && req_is_wr_i) begin
               if (fifo_wready) begin
                  push       = 1'b1;
                  fifo_wdata = wr_data_i;
                  wr_ack_d   = 1'b1;
               end else begin
                  wdata_d = wr_data_i;
                  cnt_d   = '0;
                  state_d = WR_WAIT;
               end
            end else if (req_i) begin
               if (csr_can_pop) begin
                  csr_pop   = 1'b1;
                  rd_data_d = fifo_rdata;
                  rd_ack_d  = 1'b1;
               end else begin
                  cnt_d   = '0;
                  state_d = RD_WAIT;
               end
            end
         end
         WR_WAIT: begin
            if (clr_i || fifo_wready || tmo) begin
               state_d  = IDLE;
               wr_ack_d = 1'b1;
               err_d    = clr_i | ~fifo_wready;
               push     = ~clr_i & fifo_wready;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         RD_WAIT: begin
            if (clr_i || csr_can_pop || tmo) begin
               state_d   = IDLE;
               rd_ack_d  = 1'b1;
               err_d     = ~csr_can_pop;
               csr_pop   = csr_can_pop;
               rd_data_d = csr_can_pop ? fifo_rdata : '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         wdata_q   <= '0;
         rd_data_q <= '0;
         wr_ack_q  <= 1'b0;
         rd_ack_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wdata_q   <= wdata_d;
         rd_data_q <= rd_data_d;
         wr_ack_q  <= wr_ack_d;
         rd_ack_q  <= rd_ack_d;
         err_q     <= err_d;
      end
   end

   assign wr_ack_o  = wr_ack_q;
   assign rd_ack_o  = rd_ack_q;
   assign err_o     = err_q;
   assign rd_data_o = rd_data_q;

`ifdef I3C_FIFO_BRIDGE_STATS_EN
   logic [StatCntW-1:0] ovf_cnt_q, ovf_cnt_d, unf_cnt_q, unf_cnt_d;
   logic                wr_tmo, rd_tmo;

   // Only genuine timeouts count; flush aborts are not starvation events.
   assign wr_tmo = (state_q == WR_WAIT) & ~clr_i & ~fifo_wready & tmo;
   assign rd_tmo = (state_q == RD_WAIT) & ~csr_can_pop & ~clr_i & tmo;

   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      unf_cnt_d = unf_cnt_q;
      if (clr_i) begin
         ovf_cnt_d = '0;
         unf_cnt_d = '0;
      end else begin
         if (wr_tmo && ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + 1'b1;
         if (rd_tmo && unf_cnt_q != '1) unf_cnt_d = unf_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ovf_cnt_q <= '0;
         unf_cnt_q <= '0;
      end else begin
         ovf_cnt_q <= ovf_cnt_d;
         unf_cnt_q <= unf_cnt_d;
      end
   end

   assign ovf_cnt_o = ovf_cnt_q;
   assign unf_cnt_o = unf_cnt_q;
`else
   assign ovf_cnt_o = '0;
   assign unf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_csr_fifo_port_bridge.sv
// Directed bench for csr_fifo_port_bridge: an ack scoreboard is filled as requests are issued
// and drained by a monitor, while the main sequence checks latencies and occupancy.
module tb_csr_fifo_port_bridge;
`ifdef I3C_FIFO_BRIDGE_STATS_EN
   localparam int Stats = 1;
`else
   localparam int Stats = 0;
`endif

   typedef struct {
      bit          is_rd;
      bit          err;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  depth;
   logic        full, empty;
   logic [15:0] ovf, unf;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_ack = 0;
   int          lat;
   int          ack0;
   exp_t        sb[$];

   csr_fifo_port_bridge_if #(.Width(32)) bus();

   csr_fifo_port_bridge dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .clr_i        (bus.clr),
      .req_i        (bus.req),
      .req_is_wr_i  (bus.req_is_wr),
      .wr_data_i    (bus.wr_data),
      .wr_ack_o     (bus.wr_ack),
      .rd_ack_o     (bus.rd_ack),
      .rd_data_o    (bus.rd_data),
      .err_o        (bus.err),
      .ext_rvalid_o (bus.ext_rvalid),
      .ext_rready_i (bus.ext_rready),
      .ext_rdata_o  (bus.ext_rdata),
      .depth_o      (depth),
      .full_o       (full),
      .empty_o      (empty),
      .ovf_cnt_o    (ovf),
      .unf_cnt_o    (unf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One-cycle request pulse; the expected ack is queued as the stimulus goes out.
   task automatic req_pulse(input bit wr, input logic [31:0] d, input bit e_err,
                            input logic [31:0] e_rd);
      sb.push_back('{is_rd: !wr, err: e_err, rdata: e_rd});
      bus.req       = 1'b1;
      bus.req_is_wr = wr;
      bus.wr_data   = d;
      cyc(1);
      bus.req     = 1'b0;
      bus.wr_data = '0;
   endtask

   // lat = 1 means the ack is visible in the cycle right after the request.
   task automatic wait_ack(input int start, output int l);
      l = start;
      while (!(bus.wr_ack || bus.rd_ack) && l < 200) begin
         cyc(1);
         l++;
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.wr_ack || bus.rd_ack) begin
            exp_t e;
            n_ack++;
            chk("sb_has_entry", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("ack_dir", 32'(bus.rd_ack), 32'(e.is_rd));
               chk("ack_both", 32'(bus.wr_ack & bus.rd_ack), 0);
               chk("ack_err", 32'(bus.err), 32'(e.err));
               if (e.is_rd) chk("rd_data", bus.rd_data, e.rdata);
            end
         end else begin
            chk("err_without_ack", 32'(bus.err), 0);
         end
      end
   end

   initial begin
      bus.req = 1'b0; bus.req_is_wr = 1'b0; bus.wr_data = '0;
      bus.clr = 1'b0; bus.ext_rready = 1'b0;
      cyc(2);
      chk("rst_wr_ack", 32'(bus.wr_ack), 0);
      chk("rst_rd_ack", 32'(bus.rd_ack), 0);
      chk("rst_err", 32'(bus.err), 0);
      chk("rst_rd_data", bus.rd_data, 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_depth", 32'(depth), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_unf", 32'(unf), 0);
      chk("rst_ext_rvalid", 32'(bus.ext_rvalid), 0);
      rst_n = 1'b1;
      cyc(1);

      // Basic write then read.
      req_pulse(1'b1, 32'hA5A5_0001, 1'b0, '0);
      chk("wr_lat1", 32'(bus.wr_ack), 1);
      chk("depth_after_wr", 32'(depth), 1);
      req_pulse(1'b0, '0, 1'b0, 32'hA5A5_0001);
      chk("rd_lat1", 32'(bus.rd_ack), 1);
      chk("depth_after_rd", 32'(depth), 0);

      // Fill, then a write that must time out.
      for (int i = 0; i < 64; i++) req_pulse(1'b1, 32'h1000 + i, 1'b0, '0);
      chk("fill_full", 32'(full), 1);
      chk("fill_depth", 32'(depth), 64);
      chk("fill_ext_rvalid", 32'(bus.ext_rvalid), 1);
      req_pulse(1'b1, 32'h0000_DEAD, 1'b1, '0);
      wait_ack(1, lat);
      chk("wr_tmo_lat", 32'(lat), 17);
      chk("wr_tmo_err", 32'(bus.err), 1);
      chk("wr_tmo_depth", 32'(depth), 64);
      chk("wr_tmo_ovf", 32'(ovf), 32'(Stats));

      // Full, write waits, ext pop frees a slot three cycles later.
      req_pulse(1'b1, 32'h0000_BEEF, 1'b0, '0);
      cyc(2);
      chk("ext_head", bus.ext_rdata, 32'h1000);
      bus.ext_rready = 1'b1;
      cyc(1);
      bus.ext_rready = 1'b0;
      wait_ack(4, lat);
      chk("wr_retry_lat", 32'(lat), 5);
      chk("wr_retry_depth", 32'(depth), 64);
      bus.ext_rready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         chk("drain", bus.ext_rdata, (i < 63) ? 32'h1001 + i : 32'h0000_BEEF);
         cyc(1);
      end
      bus.ext_rready = 1'b0;
      chk("drain_empty", 32'(empty), 1);

      // Ext pop wins over a coincident CSR read; the CSR read times out.
      req_pulse(1'b1, 32'h0000_1234, 1'b0, '0);
      chk("one_ext_data", bus.ext_rdata, 32'h1234);
      bus.ext_rready = 1'b1;
      req_pulse(1'b0, '0, 1'b1, '0);
      bus.ext_rready = 1'b0;
      chk("race_depth", 32'(depth), 0);
      wait_ack(1, lat);
      chk("rd_tmo_lat", 32'(lat), 17);
      chk("rd_tmo_unf", 32'(unf), 32'(Stats));
      chk("rd_tmo_ovf", 32'(ovf), 32'(Stats));

      // Flush with no request pending.
      req_pulse(1'b1, 32'h11, 1'b0, '0);
      req_pulse(1'b1, 32'h22, 1'b0, '0);
      chk("pre_flush_depth", 32'(depth), 2);
      bus.clr = 1'b1;
      #1;
      chk("flush_ext_rvalid", 32'(bus.ext_rvalid), 0);
      cyc(1);
      bus.clr = 1'b0;
      chk("flush_depth", 32'(depth), 0);
      chk("flush_empty", 32'(empty), 1);
      chk("flush_ovf", 32'(ovf), 0);
      chk("flush_unf", 32'(unf), 0);

      // Push and ext pop in the same cycle keep depth.
      req_pulse(1'b1, 32'h66, 1'b0, '0);
      chk("pp_head", bus.ext_rdata, 32'h66);
      bus.ext_rready = 1'b1;
      req_pulse(1'b1, 32'h77, 1'b0, '0);
      bus.ext_rready = 1'b0;
      chk("pp_depth", 32'(depth), 1);
      chk("pp_new_head", bus.ext_rdata, 32'h77);
      req_pulse(1'b0, '0, 1'b0, 32'h77);
      chk("pp_rd_ack", 32'(bus.rd_ack), 1);

      // Read on empty FIFO aborted by clr in the wait.
      req_pulse(1'b0, '0, 1'b1, '0);
      cyc(4);
      bus.clr = 1'b1;
      cyc(1);
      bus.clr = 1'b0;
      wait_ack(6, lat);
      chk("clr_wait_lat", 32'(lat), 6);
      chk("clr_wait_rd_data", bus.rd_data, 0);

      // clr coincident with a request.
      req_pulse(1'b1, 32'h55, 1'b0, '0);
      req_pulse(1'b0, '0, 1'b0, 32'h55);
      req_pulse(1'b1, 32'h56, 1'b0, '0);
      bus.clr = 1'b1;
      req_pulse(1'b0, '0, 1'b1, '0);
      chk("clr_req_rd_ack", 32'(bus.rd_ack), 1);
      req_pulse(1'b1, 32'h99, 1'b1, '0);
      bus.clr = 1'b0;
      chk("clr_req_wr_ack", 32'(bus.wr_ack), 1);
      chk("clr_req_depth", 32'(depth), 0);

      // Reset while a write is parked in the wait state.
      for (int i = 0; i < 64; i++) req_pulse(1'b1, 32'h2000 + i, 1'b0, '0);
      req_pulse(1'b1, 32'h0000_DEA2, 1'b1, '0);
      cyc(2);
      rst_n = 1'b0;
      #1;
      sb.delete();
      chk("rst2_wr_ack", 32'(bus.wr_ack), 0);
      chk("rst2_rd_ack", 32'(bus.rd_ack), 0);
      chk("rst2_err", 32'(bus.err), 0);
      chk("rst2_rd_data", bus.rd_data, 0);
      chk("rst2_ext_rvalid", 32'(bus.ext_rvalid), 0);
      chk("rst2_ext_rdata", bus.ext_rdata, 0);
      chk("rst2_empty", 32'(empty), 1);
      chk("rst2_full", 32'(full), 0);
      chk("rst2_depth", 32'(depth), 0);
      chk("rst2_ovf", 32'(ovf), 0);
      chk("rst2_unf", 32'(unf), 0);
      cyc(2);
      rst_n = 1'b1;
      ack0 = n_ack;
      cyc(20);
      chk("no_ack_after_rst", 32'(n_ack), 32'(ack0));
      req_pulse(1'b1, 32'h42, 1'b0, '0);
      chk("post_rst_wr_ack", 32'(bus.wr_ack), 1);
      chk("post_rst_depth", 32'(depth), 1);
      cyc(2);
      chk("sb_drained", 32'(sb.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
